memory_port_arbiter: RTL and testbench
======================================

Name: memory_port_arbiter

Overview:
- Sits directly below control_section. Serves its two memory ports, the instruction fetch port and the data (load/store) port, from one shared single-port RAM bus.
- Data port has fixed priority. Accesses are serialized. Each port sees the level-request / wait handshake that control_section already uses.
- Handles byte-lane steering for stores, misalignment rejection, and a RAM acknowledge timeout.

Parameters:
- ADDR_WIDTH, 32, width of byte addresses on all ports.
- TIMEOUT_CYCLES, 16, ACCESS cycles without ram_ack before the access is aborted; must be at least 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- instruction_ready  in  1  fetch request (level)
- instruction_address  in  ADDR_WIDTH  fetch byte address
- instruction  out  32  fetched word
- instruction_wait  out  1  fetch not complete
- memory_address  in  ADDR_WIDTH  data byte address
- memory_data_store  in  32  store data, right-aligned
- memory_read  in  1  load request (level)
- memory_write  in  2  store size: 00 none, 01 byte, 10 half, 11 word
- memory_data_load  out  32  loaded aligned word
- memory_wait  out  1  data access not complete
- bus_error  out  1  one-cycle pulse: misaligned access or timeout
- ram_req  out  1  RAM access strobe
- ram_address  out  ADDR_WIDTH  word-aligned address, bits [1:0] forced to 0
- ram_write_enable  out  1  store access
- ram_byte_enable  out  4  active store lanes
- ram_write_data  out  32  lane-replicated store data
- ram_read_data  in  32  RAM read word
- ram_ack  in  1  RAM access complete

Behaviour:
- FSM states:
  - IDLE
  - ACCESS: holds an owner flag, DATA or INST.
  - RESP: one cycle.
- Reset:
  - State goes to IDLE; owner DATA; timeout counter 0.
  - instruction and memory_data_load go to 0; bus_error 0; ram_req 0.
  - Reset during ACCESS abandons the RAM transaction; any ram_ack that arrives later is ignored.
- IDLE:
  - A data request is memory_read=1 or memory_write!=00.
  - Data request present: latch address, store data and size; owner DATA; go to ACCESS.
  - Otherwise, if instruction_ready: latch instruction_address; owner INST; go to ACCESS.
  - When both are present, data wins and the fetch stays pending.
  - memory_read together with memory_write!=00 is treated as a store.
- Misaligned data access:
  - Half with addr[0]=1, or word with addr[1:0]!=0.
  - Goes straight to RESP with bus_error=1; RAM is untouched; memory_data_load is unchanged.
- Misaligned fetch (addr[1:0]!=0): same handling; instruction is set to 0x00000013 (NOP).
- ACCESS:
  - ram_req=1; ram_address and ram_write_* are driven from the latched values.
  - Byte store: ram_byte_enable = 1 << addr[1:0]; ram_write_data = byte replicated ×4.
  - Half store: ram_byte_enable = 0011 or 1100 by addr[1]; ram_write_data = half replicated ×2.
  - Word store: ram_byte_enable = 1111.
  - Loads and fetches: ram_write_enable=0, ram_byte_enable=0000.
  - On ram_ack: capture ram_read_data into instruction (INST) or memory_data_load (DATA; stores leave it unchanged); go to RESP.
  - Timeout counter increments each ACCESS cycle without ram_ack. At TIMEOUT_CYCLES-1: go to RESP, pulse bus_error, load 0 into the owner's data output.
- RESP:
  - ram_req=0. The owner's wait is 0 and its data output is valid.
  - Go to IDLE; requests are resampled on the next cycle.
- Wait outputs (combinational):
  - instruction_wait = instruction_ready and not (state=RESP with owner INST).
  - memory_wait: same rule for the data port.
  - Both are 0 when the port's request is low.
- Data outputs hold their value until the next completion for the same port.
- Latency, request seen in IDLE at cycle N with ram_ack at cycle N+k (k≥1): ACCESS spans N+1..N+k, RESP at N+k+1. The minimum with ram_ack at N+1 is a completion 2 cycles after the request is seen, so a continuously held request issues one access every 3 cycles.
- Dropping a request mid-ACCESS does not cancel the access; the result is still captured.
- ram_ack outside ACCESS is ignored.

Decomposition:
- Shared package mem_pkg holds:
  - the size encoding constants MEM_NONE/BYTE/HALF/WORD (00/01/10/11);
  - the FSM state typedef;
  - the NOP constant 0x00000013.
- Sub-module store_lane_steer (combinational): size, addr[1:0], data → byte_enable, write_data, misaligned.
- FSM, timeout counter and capture registers stay in the top module.

Test Plan:
- Fetch, addr 0x100, RAM acks 1 cycle after ram_req → ram_address 0x100, instruction = RAM word, instruction_wait falls 2 cycles after the request is seen.
- Simultaneous fetch 0x200 and load 0x400 → load served first (ram_address 0x400), then the fetch; instruction_wait stays high throughout the data access.
- Byte store of 0xAB at 0x403 → ram_byte_enable 1000, ram_write_data 0xABABABAB. Half store of 0x1234 at 0x402 → enable 1100, data 0x12341234.
- Word store at 0x402 → no ram_req, bus_error pulse, memory_wait low in the next cycle.
- Load with no ram_ack and TIMEOUT_CYCLES=16 → abort after 16 ACCESS cycles; memory_data_load=0; bus_error pulses once.
- rst asserted mid-ACCESS, then a late ram_ack → ram_req=0 from the next edge; FSM in IDLE; late ack ignored; outputs 0.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared constants and types for the memory port arbiter.
// Holds the store-size encoding, the FSM state type with its state constants,
// the owner flag values and the NOP word returned for misaligned fetches.
package mem_pkg;
    localparam logic [1:0] MEM_NONE = 2'b00;
    localparam logic [1:0] MEM_BYTE = 2'b01;
    localparam logic [1:0] MEM_HALF = 2'b10;
    localparam logic [1:0] MEM_WORD = 2'b11;
    typedef logic [1:0] state_t;
    localparam state_t S_IDLE   = 2'd0;
    localparam state_t S_ACCESS = 2'd1;
    localparam state_t S_RESP   = 2'd2;
    localparam logic OWN_DATA = 1'b0;
    localparam logic OWN_INST = 1'b1;
    localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/store_lane_steer.sv
// store_lane_steer: combinational byte-lane steering and alignment check for stores.
// Ports: size (store size code), addr_lo (byte offset), data (right-aligned store data)
//        -> byte_enable (active lanes), write_data (lane-replicated data),
//           misaligned (half on odd offset or word on non-zero offset).
module store_lane_steer
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] data,
    output logic [3:0]  byte_enable,
    output logic [31:0] write_data,
    output logic        misaligned
);
    assign byte_enable = size == MEM_BYTE ? 4'b0001 << addr_lo :
                         size == MEM_HALF ? (addr_lo[1] ? 4'b1100 : 4'b0011) :
                         size == MEM_WORD ? 4'b1111 : 4'b0000;
    assign write_data  = size == MEM_BYTE ? {4{data[7:0]}} :
                         size == MEM_HALF ? {2{data[15:0]}} : data;
    assign misaligned  = (size == MEM_HALF && addr_lo[0]) ||
                         (size == MEM_WORD && addr_lo != 2'b00);
endmodule

// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter: serializes the fetch and data ports onto one RAM bus, data first.
// Ports: fetch side (instruction_ready/address -> instruction, instruction_wait),
//        data side (memory_address/data_store/read/write -> memory_data_load, memory_wait),
//        bus_error pulse, and the RAM bus (ram_req/address/write_enable/byte_enable/
//        write_data out, ram_read_data/ram_ack in).
module memory_port_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  instruction_ready,
    input  logic [ADDR_WIDTH-1:0] instruction_address,
    output logic [31:0]           instruction,
    output logic                  instruction_wait,
    input  logic [ADDR_WIDTH-1:0] memory_address,
    input  logic [31:0]           memory_data_store,
    input  logic                  memory_read,
    input  logic [1:0]            memory_write,
    output logic [31:0]           memory_data_load,
    output logic                  memory_wait,
    output logic                  bus_error,
    output logic                  ram_req,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_write_enable,
    output logic [3:0]            ram_byte_enable,
    output logic [31:0]           ram_write_data,
    input  logic [31:0]           ram_read_data,
    input  logic                  ram_ack
);
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    state_t                state;
    logic                  owner;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [1:0]            size_q;
    logic [CW-1:0]         cnt;
    logic                  data_req, idle, wr, misaligned;
    logic [1:0]            steer_size, steer_lo;
    logic [31:0]           steer_data, steer_wd;
    logic [3:0]            steer_be;

    assign data_req = memory_read || memory_write != MEM_NONE;
    assign idle     = state == S_IDLE;
    // In IDLE the steer checks the incoming request for alignment; afterwards it
    // steers the latched store onto the bus.
    assign steer_size = idle ? memory_write : size_q;
    assign steer_lo   = idle ? memory_address[1:0] : addr_q[1:0];
    assign steer_data = idle ? memory_data_store : wdata_q;

    store_lane_steer u_steer (
        .size        (steer_size),
        .addr_lo     (steer_lo),
        .data        (steer_data),
        .byte_enable (steer_be),
        .write_data  (steer_wd),
        .misaligned  (misaligned)
    );

    assign ram_req          = state == S_ACCESS;
    assign ram_address      = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign wr               = ram_req && owner == OWN_DATA && size_q != MEM_NONE;
    assign ram_write_enable = wr;
    assign ram_byte_enable  = wr ? steer_be : 4'b0000;
    assign ram_write_data   = steer_wd;
    assign instruction_wait = instruction_ready && !(state == S_RESP && owner == OWN_INST);
    assign memory_wait      = data_req && !(state == S_RESP && owner == OWN_DATA);

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            owner            <= OWN_DATA;
            cnt              <= '0;
            addr_q           <= '0;
            wdata_q          <= '0;
            size_q           <= MEM_NONE;
            instruction      <= '0;
            memory_data_load <= '0;
            bus_error        <= 1'b0;
        end else begin
            bus_error <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (data_req) begin
                        owner   <= OWN_DATA;
                        addr_q  <= memory_address;
                        wdata_q <= memory_data_store;
                        size_q  <= memory_write;
                        state   <= misaligned ? S_RESP : S_ACCESS;
                        bus_error <= misaligned;
                    end else if (instruction_ready) begin
                        owner  <= OWN_INST;
                        addr_q <= instruction_address;
                        size_q <= MEM_NONE;
                        if (instruction_address[1:0] != 2'b00) begin
                            state       <= S_RESP;
                            bus_error   <= 1'b1;
                            instruction <= NOP;
                        end else begin
                            state <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    if (ram_ack) begin
                        if (owner == OWN_INST) instruction <= ram_read_data;
                        else if (size_q == MEM_NONE) memory_data_load <= ram_read_data;
                        state <= S_RESP;
                        cnt   <= '0;
                    end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                        if (owner == OWN_INST) instruction <= '0;
                        else memory_data_load <= '0;
                        state     <= S_RESP;
                        bus_error <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_memory_port_arbiter.sv
// tb_memory_port_arbiter: directed stimulus with a transaction-level model checked every cycle.
module tb_memory_port_arbiter;
    localparam int TO = 16;
    logic        clk = 0, rst = 1;
    logic        instruction_ready = 0;
    logic [31:0] instruction_address = 0;
    logic [31:0] instruction;
    logic        instruction_wait;
    logic [31:0] memory_address = 0, memory_data_store = 0;
    logic        memory_read = 0;
    logic [1:0]  memory_write = 0;
    logic [31:0] memory_data_load;
    logic        memory_wait, bus_error, ram_req, ram_write_enable;
    logic [31:0] ram_address, ram_write_data, ram_read_data;
    logic [3:0]  ram_byte_enable;
    logic        ram_ack = 0;
    int          vectors = 0, errors = 0;
    int          ack_lat = 1, req_cnt = 0;
    bit          ack_force = 0;

    memory_port_arbiter #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .instruction_ready(instruction_ready), .instruction_address(instruction_address),
        .instruction(instruction), .instruction_wait(instruction_wait),
        .memory_address(memory_address), .memory_data_store(memory_data_store),
        .memory_read(memory_read), .memory_write(memory_write),
        .memory_data_load(memory_data_load), .memory_wait(memory_wait),
        .bus_error(bus_error), .ram_req(ram_req), .ram_address(ram_address),
        .ram_write_enable(ram_write_enable), .ram_byte_enable(ram_byte_enable),
        .ram_write_data(ram_write_data), .ram_read_data(ram_read_data), .ram_ack(ram_ack)
    );

    always #5 clk = ~clk;

    assign ram_read_data = 32'hD000_0000 ^ ram_address;

    // RAM responder: ack once ram_req has been high for ack_lat cycles (0 = never).
    always @(negedge clk) begin
        req_cnt = ram_req ? req_cnt + 1 : 0;
        ram_ack = ack_force || (ram_req && ack_lat > 0 && req_cnt >= ack_lat);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding access, a response cycle, then resampling.
    bit          started = 0, m_busy = 0, m_resp = 0, m_err = 0, m_inst = 0;
    int          m_age = 0;
    logic [31:0] m_addr = 0, m_data = 0, m_instr = 0, m_load = 0;
    logic [1:0]  m_size = 0;

    always @(posedge clk) begin
        started = 1;
        if (rst) begin
            m_busy = 0; m_resp = 0; m_err = 0; m_inst = 0; m_instr = 0; m_load = 0;
        end else if (m_resp) begin
            m_resp = 0; m_err = 0;
        end else if (m_busy) begin
            m_age++;
            if (ram_ack) begin
                if (m_inst) m_instr = ram_read_data;
                else if (m_size == 0) m_load = ram_read_data;
                m_busy = 0; m_resp = 1;
            end else if (m_age == TO) begin
                if (m_inst) m_instr = 0; else m_load = 0;
                m_busy = 0; m_resp = 1; m_err = 1;
            end
        end else if (memory_read || memory_write != 0) begin
            m_inst = 0; m_addr = memory_address; m_size = memory_write; m_data = memory_data_store;
            if ((m_size == 2 && m_addr % 2 != 0) || (m_size == 3 && m_addr % 4 != 0)) begin
                m_resp = 1; m_err = 1;
            end else begin
                m_busy = 1; m_age = 0;
            end
        end else if (instruction_ready) begin
            m_inst = 1; m_addr = instruction_address; m_size = 0;
            if (m_addr % 4 != 0) begin
                m_instr = 32'h13; m_resp = 1; m_err = 1;
            end else begin
                m_busy = 1; m_age = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            int off;
            bit we;
            logic [31:0] be, wd;
            off = int'(m_addr % 4);
            we  = m_busy && !m_inst && m_size != 0;
            be  = m_size == 1 ? 32'(1 << off) : m_size == 2 ? 32'(3 << (off & 2)) : 32'd15;
            wd  = m_size == 1 ? m_data[7:0] * 32'h0101_0101 :
                  m_size == 2 ? m_data[15:0] * 32'h0001_0001 : m_data;
            chk("ram_req", {31'd0, ram_req}, {31'd0, m_busy});
            chk("bus_error", {31'd0, bus_error}, {31'd0, m_err});
            chk("instruction", instruction, m_instr);
            chk("memory_data_load", memory_data_load, m_load);
            chk("instruction_wait", {31'd0, instruction_wait},
                {31'd0, instruction_ready && !(m_resp && m_inst)});
            chk("memory_wait", {31'd0, memory_wait},
                {31'd0, (memory_read || memory_write != 0) && !(m_resp && !m_inst)});
            if (m_busy) begin
                chk("ram_address", ram_address, m_addr & ~32'h3);
                chk("ram_write_enable", {31'd0, ram_write_enable}, {31'd0, we});
                chk("ram_byte_enable", {28'd0, ram_byte_enable}, we ? be : 32'd0);
                if (we) chk("ram_write_data", ram_write_data, wd);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        tick(2);
        chk("rst ram_req", {31'd0, ram_req}, 32'd0);
        chk("rst instruction", instruction, 32'd0);
        chk("rst load", memory_data_load, 32'd0);
        chk("rst bus_error", {31'd0, bus_error}, 32'd0);
        rst = 0;
        // fetch with single-cycle ack
        instruction_ready = 1; instruction_address = 32'h100;
        tick(1);
        chk("t1 ram_address", ram_address, 32'h100);
        chk("t1 wait", {31'd0, instruction_wait}, 32'd1);
        tick(1);
        chk("t1 wait fell", {31'd0, instruction_wait}, 32'd0);
        chk("t1 instruction", instruction, 32'hD000_0100);
        instruction_ready = 0;
        tick(1);
        // simultaneous fetch and load: data first
        instruction_ready = 1; instruction_address = 32'h200;
        memory_read = 1; memory_address = 32'h400;
        tick(1);
        chk("t2 data first", ram_address, 32'h400);
        tick(1);
        chk("t2 load", memory_data_load, 32'hD000_0400);
        chk("t2 fetch still waits", {31'd0, instruction_wait}, 32'd1);
        memory_read = 0;
        tick(2);
        chk("t2 fetch addr", ram_address, 32'h200);
        tick(1);
        chk("t2 instruction", instruction, 32'hD000_0200);
        instruction_ready = 0;
        tick(1);
        // byte store
        memory_write = 2'b01; memory_address = 32'h403; memory_data_store = 32'h1234_56AB;
        tick(1);
        chk("t3 byte be", {28'd0, ram_byte_enable}, 32'h8);
        chk("t3 byte wd", ram_write_data, 32'hABAB_ABAB);
        tick(1);
        chk("t3 load kept", memory_data_load, 32'hD000_0400);
        memory_write = 0;
        tick(1);
        // half store
        memory_write = 2'b10; memory_address = 32'h402; memory_data_store = 32'hFFFF_1234;
        tick(1);
        chk("t3 half be", {28'd0, ram_byte_enable}, 32'hC);
        chk("t3 half wd", ram_write_data, 32'h1234_1234);
        tick(1);
        memory_write = 0;
        tick(1);
        // misaligned word store
        memory_write = 2'b11; memory_address = 32'h402;
        tick(1);
        chk("t4 no req", {31'd0, ram_req}, 32'd0);
        chk("t4 bus_error", {31'd0, bus_error}, 32'd1);
        chk("t4 mem wait", {31'd0, memory_wait}, 32'd0);
        memory_write = 0;
        tick(1);
        chk("t4 pulse ends", {31'd0, bus_error}, 32'd0);
        // fetch dropped mid-access is still captured
        ack_lat = 3; instruction_ready = 1; instruction_address = 32'h500;
        tick(1);
        instruction_ready = 0;
        tick(3);
        chk("drop instruction", instruction, 32'hD000_0500);
        tick(1);
        // misaligned fetch
        instruction_ready = 1; instruction_address = 32'h101;
        tick(1);
        chk("mis fetch nop", instruction, 32'h13);
        chk("mis fetch err", {31'd0, bus_error}, 32'd1);
        instruction_ready = 0;
        tick(1);
        // timeout
        ack_lat = 0; memory_read = 1; memory_address = 32'h408;
        tick(16);
        chk("to still req", {31'd0, ram_req}, 32'd1);
        tick(1);
        chk("to bus_error", {31'd0, bus_error}, 32'd1);
        chk("to load zero", memory_data_load, 32'd0);
        chk("to req off", {31'd0, ram_req}, 32'd0);
        memory_read = 0;
        tick(1);
        chk("to single pulse", {31'd0, bus_error}, 32'd0);
        // reset mid-access, then a late ack
        instruction_ready = 1; instruction_address = 32'h300;
        tick(2);
        rst = 1; instruction_ready = 0;
        tick(1);
        chk("rst2 req", {31'd0, ram_req}, 32'd0);
        chk("rst2 instruction", instruction, 32'd0);
        rst = 0; ack_force = 1;
        tick(3);
        chk("late ack req", {31'd0, ram_req}, 32'd0);
        chk("late ack instruction", instruction, 32'd0);
        chk("late ack load", memory_data_load, 32'd0);
        ack_force = 0;
        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
